// File: rtl/e_mdu.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// e_mdu -- execute-stage multiply/divide unit with private HI/LO registers.
//
// The result of mult/multu/div/divu is computed from the operands present in
// the start cycle and parked in a pending HI/LO pair. A down-counter models
// the multi-cycle latency, and the pending pair is committed to HI/LO on the
// edge where the counter reaches zero. mthi/mtlo write HI/LO directly when
// idle. mfhi/mflo read the architectural registers combinationally.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high
//   HILOtype   in   4   operation in E (0 none, 1 mult, 2 multu, 3 div,
//                       4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, else none)
//   A          in  32   forwarded rs value
//   B          in  32   forwarded rt value
//   start      out  1   combinational, 1 for HILOtype 1..4
//   HILO_BUSY  out  1   1 while an operation is in flight
//   HILO_out   out 32   HI for mfhi, LO for mflo, else 0
//   HI         out 32   architectural HI register
//   LO         out 32   architectural LO register
// ---------------------------------------------------------------------------
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  HILOtype,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        HILO_BUSY,
    output logic [31:0] HILO_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } hilo_op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE       = CW'(1);

    // Architectural and pending state.
    logic [CW-1:0] count_q,   count_d;
    logic [31:0]   hi_q,      hi_d;
    logic [31:0]   lo_q,      lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_we_q, pend_we_d;

    // ------------------------------------------------------------------
    // Arithmetic datapath (evaluated every cycle, used only on a start).
    // ------------------------------------------------------------------
    logic [63:0]        a_sx, b_sx, prod_s, prod_u;
    logic               div_ovf;
    logic [31:0]        b_div;
    logic signed [31:0] a_s, b_s, quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;

    // Sign-extending to 64 bits lets one unsigned multiply give the
    // correct signed product in its low 64 bits.
    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, A} * {32'd0, B};

    // The divisor is forced to 1 for divide-by-zero (result discarded) and
    // for 0x80000000 / -1: dividing by 1 yields LO=0x80000000, HI=0, which
    // is exactly the wrapped result, without relying on overflow behaviour.
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign b_div   = ((B == 32'd0) || div_ovf) ? 32'd1 : B;
    assign a_s     = A;
    assign b_s     = b_div;
    assign quot_s  = a_s / b_s;     // truncates toward zero
    assign rem_s   = a_s % b_s;     // takes the sign of the dividend
    assign quot_u  = A / b_div;
    assign rem_u   = A % b_div;

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        if (count_q != '0) begin
            // Busy: all incoming HILO writes are ignored.
            count_d = count_q - ONE;
            if ((count_q == ONE) && pend_we_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else begin
            case (HILOtype)
                OP_MULT: begin
                    pend_hi_d = prod_s[63:32];
                    pend_lo_d = prod_s[31:0];
                    pend_we_d = 1'b1;
                    count_d   = MULT_LOAD;
                end
                OP_MULTU: begin
                    pend_hi_d = prod_u[63:32];
                    pend_lo_d = prod_u[31:0];
                    pend_we_d = 1'b1;
                    count_d   = MULT_LOAD;
                end
                OP_DIV: begin
                    pend_hi_d = rem_s;
                    pend_lo_d = quot_s;
                    pend_we_d = (B != 32'd0);
                    count_d   = DIV_LOAD;
                end
                OP_DIVU: begin
                    pend_hi_d = rem_u;
                    pend_lo_d = quot_u;
                    pend_we_d = (B != 32'd0);
                    count_d   = DIV_LOAD;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers; synchronous reset wins over everything.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            count_q   <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign start     = (HILOtype >= OP_MULT) && (HILOtype <= OP_DIVU);
    assign HILO_BUSY = (count_q != '0);
    assign HI        = hi_q;
    assign LO        = lo_q;

    always_comb begin
        HILO_out = 32'd0;
        if (HILOtype == OP_MFHI)      HILO_out = hi_q;
        else if (HILOtype == OP_MFLO) HILO_out = lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu.
//
// Directed steps from the test plan followed by randomized operations. The
// expected HI/LO come from constants or from a reference model that uses
// plain 64-bit integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_e_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  HILOtype;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        HILO_BUSY;
    logic [31:0] HILO_out;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    // Reference architectural state.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .HILOtype  (HILOtype),
        .A         (A),
        .B         (B),
        .start     (start),
        .HILO_BUSY (HILO_BUSY),
        .HILO_out  (HILO_out),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural effect of a start with operands a/b.
    function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo);
        longint          p, sa, sb;
        longint unsigned pu;
        case (op)
            4'd1: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32];
                lo = p[31:0];
            end
            4'd2: begin
                pu = 64'(a) * 64'(b);
                hi = pu[63:32];
                lo = pu[31:0];
            end
            4'd3: if (b != 0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                lo = 32'(sa / sb);
                hi = 32'(sa % sb);
            end
            4'd4: if (b != 0) begin
                lo = a / b;
                hi = a % b;
            end
            default: ;
        endcase
    endfunction

    // Issue one start, check busy length and the committed result, then
    // read back via mflo/mfhi in the first idle cycle. Returns in that idle
    // cycle, so a following run_op issues back-to-back.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit inject);
        int n = (op <= 4'd2) ? MULT_N : DIV_N;
        HILOtype = op; A = a; B = b;
        #1;
        check({tag, ".start"}, 32'(start), 32'd1);
        tick();
        for (int i = 0; i < n; i++) begin
            HILOtype = 4'd0;
            A = $urandom; B = $urandom;
            if (inject && i == 1) begin HILOtype = 4'd7; A = 32'h0000_DEAD; end
            if (inject && i == 2) begin HILOtype = 4'd8; A = 32'h0000_BEEF; end
            #1;
            check($sformatf("%s.busy%0d", tag, i), 32'(HILO_BUSY), 32'd1);
            tick();
        end
        HILOtype = 4'd0;
        #1;
        check({tag, ".idle"}, 32'(HILO_BUSY), 32'd0);
        check({tag, ".HI"}, HI, exp_hi);
        check({tag, ".LO"}, LO, exp_lo);
        HILOtype = 4'd6;
        #1;
        check({tag, ".mflo"}, HILO_out, exp_lo);
        HILOtype = 4'd5;
        #1;
        check({tag, ".mfhi"}, HILO_out, exp_hi);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    // mthi (7) / mtlo (8) with a readback in the following cycle.
    task automatic move_to(input logic [3:0] op, input logic [31:0] val);
        HILOtype = op; A = val;
        tick();
        if (op == 4'd7) m_hi = val; else m_lo = val;
        HILOtype = (op == 4'd7) ? 4'd5 : 4'd6;
        A = $urandom;
        #1;
        check((op == 4'd7) ? "mthi.read" : "mtlo.read", HILO_out, val);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb, eh, el;

        // ---------------- reset ----------------
        reset = 1'b1; HILOtype = 4'd0; A = 32'd0; B = 32'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst.busy", 32'(HILO_BUSY), 32'd0);
        check("rst.HI", HI, 32'd0);
        check("rst.LO", LO, 32'd0);
        check("rst.start0", 32'(start), 32'd0);
        check("rst.out0", HILO_out, 32'd0);
        for (int t = 5; t < 16; t++) begin
            HILOtype = 4'(t);
            #1;
            check($sformatf("start_type%0d", t), 32'(start), 32'd0);
        end
        HILOtype = 4'd0;
        tick();

        // ---------------- directed ----------------
        run_op("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        tick();
        run_op("multu_big", 4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        // Issued in the first cycle busy is low.
        run_op("multu_b2b", 4'd2, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

        // Divide by zero leaves HI/LO untouched.
        move_to(4'd7, 32'h0000_1234);
        move_to(4'd8, 32'h0000_5678);
        run_op("divu_zero", 4'd4, 32'd7, 32'd0, 32'h0000_1234, 32'h0000_5678, 1'b0);
        run_op("div_zero", 4'd3, 32'hFFFF_0000, 32'd0, 32'h0000_1234, 32'h0000_5678, 1'b0);

        // mthi/mtlo injected while busy are ignored.
        run_op("mult_inject", 4'd1, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'd0, 1'b1);

        // Reset on the 3rd busy cycle of a div.
        HILOtype = 4'd3; A = 32'd100; B = 32'd7;
        tick();
        HILOtype = 4'd0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid.busy", 32'(HILO_BUSY), 32'd0);
        check("rstmid.HI", HI, 32'd0);
        check("rstmid.LO", LO, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        run_op("mult_after_rst", 4'd1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0);

        // ---------------- randomized ----------------
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0)
                move_to(($urandom_range(0, 1) == 0) ? 4'd7 : 4'd8, $urandom);
            op = 4'($urandom_range(1, 4));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = -32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            eh = m_hi;
            el = m_lo;
            model(op, ra, rb, eh, el);
            run_op($sformatf("rand%0d_op%0d", k, op), op, ra, rb, eh, el, 1'b0);
        end

        HILOtype = 4'd0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
